ram_mar_scrub: RTL and testbench
================================

// Module: ram_mar_scrub
// PURPOSE
//   Parametrised successor to the main memory block: DEPTH x DATA_W RAM with an internal
//   memory address register (MAR), one shared tristate data bus, and optional MAR
//   auto-increment for sequential access. Adds a scrub engine that zero-fills the whole
//   array on request. Sits on the CPU data bus; the address comes from the address bus.
// PARAMETERS
//   DATA_W    8   width of the data bus and of each memory word
//   ADDR_W    8   width of the MAR and address input; DEPTH = 2**ADDR_W (localparam)
//   AUTO_INC  1   1: the inc input is honoured; 0: inc is ignored and the MAR changes only on sa
// PORTS
//   clk    in     1       system clock; all state updates on the rising edge
//   rst    in     1       synchronous, active-high reset
//   a      in     ADDR_W  address value, loaded into the MAR on sa
//   sa     in     1       set address: MAR <= a
//   s      in     1       set: mem[MAR] <= bus
//   e      in     1       enable: drive mem[MAR] onto bus
//   inc    in     1       post-increment the MAR after an s or e access
//   clr    in     1       start a scrub (zero-fill all DEPTH words)
//   bus    inout  DATA_W  shared data bus; high-Z unless driven by this block
//   mar    out    ADDR_W  current MAR value (debug/visibility)
//   busy   out    1       high while a scrub runs
//   wrap   out    1       one-cycle pulse when an auto-increment takes the MAR from DEPTH-1 to 0
// BEHAVIOUR
//   Reset: MAR=0, busy=0, wrap=0, FSM=IDLE, scrub pointer=0, bus=high-Z. Memory contents are
//     not reset. Reset overrides all other inputs on that edge, including a scrub in progress.
//   FSM states: IDLE, SCRUB.
//   IDLE, on each rising edge:
//     - sa=1: MAR <= a.
//     - s=1: mem[MAR] <= bus (the current MAR, i.e. the value before this edge's update).
//     - Read: combinational. bus = mem[MAR] while e=1 && s=0 && busy=0; otherwise high-Z.
//     - s=1 && e=1: the write wins; the bus is not driven; only the write occurs.
//     - Auto-increment: if AUTO_INC=1, inc=1, sa=0, and (s|e)=1: MAR <= MAR+1 mod DEPTH.
//       wrap <= 1 for one cycle when the old MAR was DEPTH-1; otherwise wrap <= 0.
//     - sa=1 together with an increment condition: sa wins, so MAR <= a and wrap stays 0.
//     - clr=1: enter SCRUB next cycle; pointer <= 0; busy <= 1. If s or sa is asserted on the
//       same edge, the s write and the sa MAR load still complete on that edge.
//   SCRUB, on each edge:
//     - mem[pointer] <= 0; pointer <= pointer+1.
//     - When pointer==DEPTH-1, write it, return to IDLE, busy <= 0.
//     - busy is high for exactly DEPTH cycles.
//     - sa, s, e, inc and clr are ignored; bus stays high-Z; MAR and wrap are held (wrap=0).
//   Reset mid-scrub: return to IDLE immediately. Words already cleared stay 0; the rest keep
//     their old data.
//   Address width: a and the MAR are both ADDR_W bits. Every address is valid; no
//     out-of-range case exists.
// TESTING
//   1 Write/read: ADDR_W=8. sa with a=8'h3C, then s with bus=8'hA5, then e -> bus=8'hA5,
//     mar=8'h3C, wrap=0.
//   2 Burst: AUTO_INC=1. sa with a=8'hFE. Write 8'h11, 8'h22, 8'h33 with s&inc -> words at
//     FE/FF/00 hold 11/22/33; wrap pulses once (after the FF write); final mar=8'h01.
//   3 Priority: assert s=1, e=1 with bus driven 8'h5A -> DUT never drives bus; mem[MAR]=8'h5A.
//     Assert sa=1 with a=8'h10 and inc=1 during an e access -> mar=8'h10.
//   4 Scrub: fill all 256 words with $random, pulse clr -> busy high exactly 256 cycles.
//     Reading every address afterwards gives 8'h00. s/e pulses during busy have no effect and
//     the bus stays high-Z.
//   5 Reset mid-scrub: fill with 8'hFF, pulse clr, assert rst on busy cycle 100 -> busy=0 and
//     mar=0. Addresses 0..99 read 8'h00; addresses 100..255 read 8'hFF.
//   6 AUTO_INC=0, DATA_W=16, ADDR_W=4: s with inc=1 leaves mar unchanged. A 16'hBEEF write
//     at address 4'hF reads back intact.

Source files
------------

// File: rtl/ram_mar_scrub_if.sv
// Control/status bundle for ram_mar_scrub: address, access strobes, scrub request and MAR/status outputs.
// The shared data bus stays a plain inout port on the memory block itself.
interface ram_mar_scrub_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] a;
    logic              sa;
    logic              s;
    logic              e;
    logic              inc;
    logic              clr;
    logic [ADDR_W-1:0] mar;
    logic              busy;
    logic              wrap;

    modport master (
        output a, sa, s, e, inc, clr,
        input  mar, busy, wrap
    );

    modport slave (
        input  a, sa, s, e, inc, clr,
        output mar, busy, wrap
    );
endinterface

// File: rtl/ram_mar_scrub.sv
// DEPTH x DATA_W RAM addressed through an internal MAR, sharing one tristate data bus,
// with optional MAR post-increment and a scrub engine that zero-fills the array.
module ram_mar_scrub #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter bit          AUTO_INC = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    ram_mar_scrub_if.slave     bif,
    inout  wire [DATA_W-1:0]   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  mar_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic               busy_q;
    logic               wrap_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               inc_ok_c;
    logic               drive_c;
    logic               mar_last_c;
    logic               ptr_last_c;

    // Increment applies only to an actual access; a concurrent sa takes priority below.
    assign inc_ok_c   = AUTO_INC && bif.inc && (bif.s || bif.e);
    assign mar_last_c = (mar_q == {ADDR_W{1'b1}});
    assign ptr_last_c = (ptr_q == {ADDR_W{1'b1}});

    // Read is combinational; a simultaneous write keeps the bus released.
    assign drive_c = (state == IDLE) && bif.e && !bif.s;
    assign bus     = drive_c ? mem[mar_q] : {DATA_W{1'bz}};

    // Control FSM: MAR, wrap pulse, scrub pointer and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mar_q  <= '0;
            ptr_q  <= '0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wrap_q <= 1'b0;
                    if (bif.sa) begin
                        mar_q <= bif.a;
                    end else if (inc_ok_c) begin
                        mar_q  <= mar_q + ADDR_W'(1);
                        wrap_q <= mar_last_c;
                    end
                    if (bif.clr) begin
                        state  <= SCRUB;
                        ptr_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SCRUB: begin
                    wrap_q <= 1'b0;
                    ptr_q  <= ptr_q + ADDR_W'(1);
                    if (ptr_last_c) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    wrap_q <= 1'b0;
                end
            endcase
        end
    end

    // Array storage is never reset; reset only blocks the write on its own edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == SCRUB) begin
                mem[ptr_q] <= '0;
            end else if (bif.s) begin
                mem[mar_q] <= bus;
            end
        end
    end

    assign bif.mar  = mar_q;
    assign bif.busy = busy_q;
    assign bif.wrap = wrap_q;

endmodule

// File: tb/tb_ram_mar_scrub.sv
// Randomized and directed checks of ram_mar_scrub against a behavioural array model,
// plus a small AUTO_INC=0 / 16-bit instance.
module tb_ram_mar_scrub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: DATA_W=8, ADDR_W=8, AUTO_INC=1
    ram_mar_scrub_if #(.ADDR_W(8)) bif0 ();
    wire  [7:0] bus0;
    logic [7:0] drv0 = 8'h00;
    logic       drv0_en = 1'b0;
    assign bus0 = drv0_en ? drv0 : {8{1'bz}};

    ram_mar_scrub #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bif (bif0),
        .bus (bus0)
    );

    // Second instance: DATA_W=16, ADDR_W=4, AUTO_INC=0
    ram_mar_scrub_if #(.ADDR_W(4)) bif1 ();
    wire  [15:0] bus1;
    logic [15:0] drv1 = 16'h0000;
    logic        drv1_en = 1'b0;
    assign bus1 = drv1_en ? drv1 : {16{1'bz}};

    ram_mar_scrub #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bif (bif1),
        .bus (bus1)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus must be released; an undriven net reads as z (4-state) or 0 (2-state).
    task automatic chk_rel(input string name);
        n_chk++;
        if (!($isunknown(bus0) || bus0 == 8'h00)) begin
            n_err++;
            $display("FAIL %s: bus driven with %0h expected released (t=%0t)", name, bus0, $time);
        end
    endtask

    // ---------------- behavioural model of the 8-bit instance ----------------
    logic [7:0] m_mem [256];
    bit         m_valid [256];
    int         m_mar = 0;
    int         m_ptr = 0;
    bit         m_busy = 1'b0;
    bit         m_wrap = 1'b0;
    bit         model_ok = 1'b0;

    always @(posedge clk) begin
        bit step;
        if (rst) begin
            m_mar = 0; m_ptr = 0; m_busy = 1'b0; m_wrap = 1'b0; model_ok = 1'b1;
        end else if (m_busy) begin
            m_mem[m_ptr] = 8'h00;
            m_valid[m_ptr] = 1'b1;
            m_wrap = 1'b0;
            m_ptr = m_ptr + 1;
            if (m_ptr == 256) m_busy = 1'b0;
        end else begin
            if (bif0.s) begin
                m_mem[m_mar] = bus0;
                m_valid[m_mar] = 1'b1;
            end
            step   = bif0.inc && (bif0.s || bif0.e);
            m_wrap = !bif0.sa && step && (m_mar == 255);
            if (bif0.sa)   m_mar = int'(bif0.a);
            else if (step) m_mar = (m_mar + 1) % 256;
            if (bif0.clr) begin
                m_busy = 1'b1;
                m_ptr  = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("mar", 32'(bif0.mar), 32'(m_mar));
            chk("busy", 32'(bif0.busy), 32'(m_busy));
            chk("wrap", 32'(bif0.wrap), 32'(m_wrap));
            if (!m_busy && bif0.e && !bif0.s) begin
                if (m_valid[m_mar]) chk("read", 32'(bus0), 32'(m_mem[m_mar]));
            end else if (!bif0.s) begin
                chk_rel("bus_release");
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic sa_, input logic s_, input logic e_, input logic inc_,
                          input logic clr_, input logic [7:0] a_, input logic [7:0] d_);
        bif0.sa  = sa_;
        bif0.s   = s_;
        bif0.e   = e_;
        bif0.inc = inc_;
        bif0.clr = clr_;
        bif0.a   = a_;
        drv0     = d_;
        drv0_en  = s_;
    endtask

    task automatic idle1();
        bif1.sa = 1'b0; bif1.s = 1'b0; bif1.e = 1'b0; bif1.inc = 1'b0; bif1.clr = 1'b0;
        bif1.a = 4'h0; drv1_en = 1'b0;
    endtask

    task automatic wait_not_busy();
        for (int k = 0; k < 300 && bif0.busy; k++) tick();
        chk("scrub_done", 32'(bif0.busy), 32'd0);
    endtask

    task automatic fill_from0(input bit rand_data, input logic [7:0] val);
        set_in(1, 0, 0, 0, 0, 8'h00, 8'h00); tick();
        for (int i = 0; i < 256; i++) begin
            set_in(0, 1, 0, 1, 0, 8'h00, rand_data ? 8'($urandom) : val);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        logic [7:0] expv;

        set_in(0, 0, 0, 0, 0, 8'h00, 8'h00);
        idle1();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_mar", 32'(bif0.mar), 32'd0);
        chk("rst_busy", 32'(bif0.busy), 32'd0);
        chk("rst_wrap", 32'(bif0.wrap), 32'd0);
        chk("rst_mar1", 32'(bif1.mar), 32'd0);
        #1 chk_rel("rst_bus");

        // Write then read at 3C
        set_in(1, 0, 0, 0, 0, 8'h3C, 8'h00); tick();
        set_in(0, 1, 0, 0, 0, 8'h00, 8'hA5); tick();
        set_in(0, 0, 1, 0, 0, 8'h00, 8'h00); #1;
        chk("t1_bus", 32'(bus0), 32'hA5);
        chk("t1_mar", 32'(bif0.mar), 32'h3C);
        chk("t1_wrap", 32'(bif0.wrap), 32'd0);
        tick();

        // Burst across the top of the array
        set_in(1, 0, 0, 0, 0, 8'hFE, 8'h00); tick();
        set_in(0, 1, 0, 1, 0, 8'h00, 8'h11); tick();
        chk("t2_mar_a", 32'(bif0.mar), 32'hFF); chk("t2_wrap_a", 32'(bif0.wrap), 32'd0);
        set_in(0, 1, 0, 1, 0, 8'h00, 8'h22); tick();
        chk("t2_mar_b", 32'(bif0.mar), 32'h00); chk("t2_wrap_b", 32'(bif0.wrap), 32'd1);
        set_in(0, 1, 0, 1, 0, 8'h00, 8'h33); tick();
        chk("t2_mar_c", 32'(bif0.mar), 32'h01); chk("t2_wrap_c", 32'(bif0.wrap), 32'd0);
        set_in(1, 0, 0, 0, 0, 8'hFE, 8'h00); tick();
        set_in(0, 0, 1, 1, 0, 8'h00, 8'h00);
        #1 chk("t2_rd_fe", 32'(bus0), 32'h11); tick();
        #1 chk("t2_rd_ff", 32'(bus0), 32'h22); tick();
        #1 chk("t2_rd_00", 32'(bus0), 32'h33); tick();

        // Write wins over read; sa wins over increment
        set_in(1, 0, 0, 0, 0, 8'h40, 8'h00); tick();
        set_in(0, 1, 1, 0, 0, 8'h00, 8'h5A);
        #1 chk("t3_bus_we", 32'(bus0), 32'h5A);
        tick();
        set_in(0, 0, 1, 0, 0, 8'h00, 8'h00);
        #1 chk("t3_mem", 32'(bus0), 32'h5A);
        set_in(1, 0, 1, 1, 0, 8'h10, 8'h00); tick();
        chk("t3_mar", 32'(bif0.mar), 32'h10);
        chk("t3_wrap", 32'(bif0.wrap), 32'd0);

        // Randomized traffic including occasional scrubs and resets
        for (int i = 0; i < 1500; i++) begin
            set_in(($urandom_range(3) == 0), ($urandom_range(2) == 0), $urandom_range(1) == 1,
                   $urandom_range(1) == 1, ($urandom_range(149) == 0), 8'($urandom), 8'($urandom));
            rst = ($urandom_range(399) == 0);
            tick();
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 8'h00, 8'h00);
        tick();
        wait_not_busy();

        // Full scrub of random contents with traffic ignored while busy
        fill_from0(1'b1, 8'h00);
        set_in(0, 0, 0, 0, 1, 8'h00, 8'h00); tick();
        cnt = 0;
        while (bif0.busy && cnt < 400) begin
            cnt++;
            set_in($urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1,
                   $urandom_range(1) == 1, $urandom_range(1) == 1, 8'($urandom), 8'($urandom));
            tick();
        end
        set_in(0, 0, 0, 0, 0, 8'h00, 8'h00);
        chk("t4_busy_cycles", 32'(cnt), 32'd256);
        wait_not_busy();
        set_in(1, 0, 0, 0, 0, 8'h00, 8'h00); tick();
        for (int i = 0; i < 256; i++) begin
            set_in(0, 0, 1, 1, 0, 8'h00, 8'h00);
            #1 chk("t4_zero", 32'(bus0), 32'h00);
            tick();
        end

        // Reset during busy cycle 100 leaves words 100..255 untouched
        set_in(0, 0, 0, 0, 0, 8'h00, 8'h00);
        fill_from0(1'b0, 8'hFF);
        set_in(0, 0, 0, 0, 1, 8'h00, 8'h00); tick();
        set_in(0, 0, 0, 0, 0, 8'h00, 8'h00);
        repeat (100) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("t5_busy", 32'(bif0.busy), 32'd0);
        chk("t5_mar", 32'(bif0.mar), 32'd0);
        set_in(1, 0, 0, 0, 0, 8'h00, 8'h00); tick();
        for (int i = 0; i < 256; i++) begin
            expv = (i < 100) ? 8'h00 : 8'hFF;
            set_in(0, 0, 1, 1, 0, 8'h00, 8'h00);
            #1 chk("t5_word", 32'(bus0), 32'(expv));
            tick();
        end
        set_in(0, 0, 0, 0, 0, 8'h00, 8'h00);

        // AUTO_INC=0, 16-bit data, 4-bit address
        bif1.sa = 1'b1; bif1.a = 4'hF; tick();
        bif1.sa = 1'b0; bif1.s = 1'b1; bif1.inc = 1'b1; drv1 = 16'hBEEF; drv1_en = 1'b1; tick();
        chk("t6_mar_w", 32'(bif1.mar), 32'hF);
        chk("t6_wrap", 32'(bif1.wrap), 32'd0);
        bif1.s = 1'b0; drv1_en = 1'b0; bif1.e = 1'b1;
        #1 chk("t6_read", 32'(bus1), 32'hBEEF);
        tick();
        chk("t6_mar_r", 32'(bif1.mar), 32'hF);
        idle1();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
